// File: rtl/dram_bank_shifter.sv
// Serially mirrors a parallel word through a 1-bit distributed RAM and shows the read-back word.
// Define DRAM_SHIFTER_CLEAR_EN to zero every RAM location after reset before the first sweep.
module dram_bank_shifter #(
   parameter int unsigned IO_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned BANK_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IO_WIDTH-1:0]   in,
   input  logic [BANK_BITS-1:0]  bank_sel,
   input  logic                  freeze,
   output logic [IO_WIDTH-1:0]   out,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [BANK_BITS-1:0]  bank,
   output logic                  ram_we,
   output logic                  ram_in,
   input  logic                  ram_out,
   output logic                  scan_done
);

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(IO_WIDTH - 1);

   logic [ADDR_WIDTH-1:0] addr_q, addr_run;
   logic [BANK_BITS-1:0]  bank_q, bank_run;
   logic [IO_WIDTH-1:0]   out_q, out_run;
   logic [IO_WIDTH-1:0]   shadow_q, shadow_run;
   logic                  scan_done_q;
   logic                  sweep_end;
   logic                  in_bit;
   logic                  run;

   // Bit select by comparison so the address width never has to match the word width.
   always_comb begin
      in_bit     = 1'b0;
      shadow_run = shadow_q;
      for (int i = 0; i < int'(IO_WIDTH); i++) begin
         if (addr_q == ADDR_WIDTH'(i)) begin
            in_bit        = in[i];
            shadow_run[i] = ram_out;
         end
      end
   end

   // The last bit is taken straight from ram_out so the whole word lands in one edge.
   always_comb begin
      sweep_end = (addr_q == LastAddr);
      addr_run  = sweep_end ? '0 : addr_q + ADDR_WIDTH'(1);
      bank_run  = sweep_end ? bank_sel : bank_q;
      out_run   = sweep_end ? shadow_run : out_q;
   end

`ifdef DRAM_SHIFTER_CLEAR_EN
   localparam int unsigned LocBits = ADDR_WIDTH + BANK_BITS;

   typedef enum logic {StClear, StRun} state_e;
   state_e state_q;

   assign run = (state_q == StRun);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         addr_q      <= '0;
         bank_q      <= '0;
         out_q       <= '0;
         shadow_q    <= '0;
         scan_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            StClear: begin
               scan_done_q <= 1'b0;
               if (&{bank_q, addr_q}) begin
                  state_q <= StRun;
                  addr_q  <= '0;
                  bank_q  <= bank_sel;
               end else begin
                  {bank_q, addr_q} <= {bank_q, addr_q} + LocBits'(1);
               end
            end
            StRun: begin
               addr_q      <= addr_run;
               bank_q      <= bank_run;
               out_q       <= out_run;
               shadow_q    <= shadow_run;
               scan_done_q <= sweep_end;
            end
            default: state_q <= StClear;
         endcase
      end
   end
`else
   assign run = 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         bank_q      <= '0;
         out_q       <= '0;
         shadow_q    <= '0;
         scan_done_q <= 1'b0;
      end else begin
         addr_q      <= addr_run;
         bank_q      <= bank_run;
         out_q       <= out_run;
         shadow_q    <= shadow_run;
         scan_done_q <= sweep_end;
      end
   end
`endif

   // Writes are held off while reset is asserted so a held reset never disturbs the RAM.
   always_comb begin
      addr      = addr_q;
      bank      = bank_q;
      out       = out_q;
      scan_done = scan_done_q;
      ram_in    = run ? in_bit : 1'b0;
      ram_we    = !rst && (run ? !freeze : 1'b1);
   end

endmodule
